acu_arb: RTL and testbench
==========================

# acu_arb

Arbiter and access sequencer for the shared address calculation unit. Two requesters need effective addresses from the single registered ACU: the decoder memory-operand path and the stack/string microsequencer. This block grants one requester at a time, steers the ACU input mux, and captures the computed linear address and segment. It then issues one or two byte-enabled bus beats, splitting any access that crosses a dword boundary.

## Interface
Parameters:
- AW, 32, address width. Beat-1 address arithmetic is modulo 2^AW.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- dec_req  in  1  decoder requests an address calculation plus access.
- dec_size  in  2  decoder access size: 0 = byte, 1 = word, 2 = dword, 3 = treated as dword.
- dec_wr  in  1  decoder access is a write.
- dec_gnt  out  1  one-cycle pulse: decoder request accepted and its address captured.
- seq_req, seq_size, seq_wr, seq_gnt: the same set of signals for the microsequencer.
- acu_sel  out  1  ACU input mux select: 0 = decoder fields, 1 = microsequencer fields.
- acu_addr  in  AW  registered ACU address output.
- acu_seg  in  3  registered ACU segment select.
- mem_req  out  1  bus beat valid.
- mem_addr  out  AW  beat address.
- mem_be  out  4  byte enables.
- mem_seg  out  3  segment of the access.
- mem_wr  out  1  write flag.
- mem_src  out  1  owner of the beat: 0 = decoder, 1 = microsequencer.
- mem_last  out  1  current beat is the final beat.
- mem_ack  in  1  bus accepts the current beat.
- dec_done, seq_done  out  1  one-cycle pulse after the final beat of that requester is acked.

## Operation
- State machine states: IDLE, CALC, CAP, BEAT0, BEAT1.
- IDLE: samples dec_req and seq_req.
  - One request active: that requester wins.
  - Both active: round-robin. The winner is the requester not granted last.
  - last_gnt resets to "seq", so the decoder wins the first tie.
  - With a winner: register acu_sel := winner, size, wr, src; go to CALC.
- CALC: acu_sel is held. The ACU samples the selected fields at the end of this cycle. Go to CAP.
- CAP: acu_sel is held.
  - Register a := acu_addr and seg := acu_seg.
  - Pulse the winner's gnt; update last_gnt.
  - Go to BEAT0.
- Requester protocol: req and operand fields stay stable from assertion until gnt. req is sampled only in IDLE; dropping it after IDLE does not abort the sequence.
- Byte count n: 1, 2 or 4 from size (3 gives 4).
- m8 = ((1<<n)-1) << a[1:0], 8 bits wide.
- split = (a[1:0] + n > 4), i.e. m8[7:4] != 0.
- BEAT0: mem_req=1, mem_addr=a, mem_be=m8[3:0], mem_last=~split.
  - On mem_ack: go to BEAT1 if split, else go to IDLE.
- BEAT1: mem_req=1, mem_addr={a[AW-1:2]+1, 2'b00} (wraps to 0 past the top), mem_be=m8[7:4], mem_last=1.
  - On mem_ack: go to IDLE.
- mem_seg, mem_wr and mem_src are constant across both beats.
- All mem_* outputs hold stable while mem_req=1 and mem_ack=0.
- mem_ack is ignored when mem_req=0.
- done: a registered pulse of src's done signal in the cycle after the final ack. That cycle is IDLE, so a new arbitration happens in that same cycle.

## Timing
- Reset values: state=IDLE, acu_sel=0, last_gnt=seq, and all of the following at 0: dec_gnt, seq_gnt, mem_req, mem_addr, mem_be, mem_seg, mem_wr, mem_src, mem_last, dec_done, seq_done.
- Request sampled in IDLE at cycle T:
  - acu_sel valid at T+1 (CALC).
  - gnt pulse at T+2 (CAP).
  - mem_req first high at T+3.
- With zero wait states:
  - Non-split access: done at T+4.
  - Split access: done at T+5.
- Back-to-back throughput: one new grant per 4 cycles (non-split, ack in the same cycle as mem_req).
- rst high mid-sequence in any state: the next edge returns the block to IDLE with all outputs at their reset values. No done pulse and no beat continues; the partially issued access is abandoned.
- rst wins over simultaneous req or mem_ack.

## Test plan
- Reset, then dec_req=1 alone with size=2 and acu_addr=0x00001000:
  - Required: acu_sel=0 at T+1, dec_gnt at T+2.
  - Required: one beat with addr=0x00001000, be=1111, last=1; dec_done at T+4.
- seq_req with size=1 and acu_addr=0x00002003:
  - Required: beat0 addr=0x00002003, be=1000, last=0.
  - Required: beat1 addr=0x00002004, be=0001, last=1; seq_done once.
- Dword at acu_addr=0xFFFFFFFE:
  - Required: beat0 be=1100.
  - Required: beat1 addr=0x00000000, be=0011.
- dec_req and seq_req both held high for three accesses:
  - Required: grants follow dec, seq, dec.
  - Required: acu_sel matches each owner through CALC and CAP.
- mem_ack held low for 5 cycles in BEAT0:
  - Required: all mem_* outputs stable; no early done.
- rst pulsed during BEAT1:
  - Required: mem_req=0 and state IDLE the next cycle; no done pulse.
  - Required: the next tie grants the decoder.

Source files
------------

// File: rtl/acu_arb.sv
// Two-requester arbiter for the shared ACU: grants one requester, steers the ACU
// input mux, captures the linear address and issues one or two byte-enabled beats.
module acu_arb #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_req,
    input  logic [1:0]    dec_size,
    input  logic          dec_wr,
    output logic          dec_gnt,
    input  logic          seq_req,
    input  logic [1:0]    seq_size,
    input  logic          seq_wr,
    output logic          seq_gnt,
    output logic          acu_sel,
    input  logic [AW-1:0] acu_addr,
    input  logic [2:0]    acu_seg,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [2:0]    mem_seg,
    output logic          mem_wr,
    output logic          mem_src,
    output logic          mem_last,
    input  logic          mem_ack,
    output logic          dec_done,
    output logic          seq_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_CAP   = 3'd2,
        S_BEAT0 = 3'd3,
        S_BEAT1 = 3'd4
    } state_t;

    state_t        r_state,    w_state;
    logic          r_sel,      w_sel;
    logic          r_last_seq, w_last_seq;
    logic [1:0]    r_size,     w_size;
    logic          r_wr,       w_wr;
    logic [3:0]    r_hi_be,    w_hi_be;
    logic [AW-1:0] r_a1,       w_a1;
    logic          r_dec_gnt,  w_dec_gnt;
    logic          r_seq_gnt,  w_seq_gnt;
    logic          r_mem_req,  w_mem_req;
    logic [AW-1:0] r_mem_addr, w_mem_addr;
    logic [3:0]    r_mem_be,   w_mem_be;
    logic [2:0]    r_mem_seg,  w_mem_seg;
    logic          r_mem_wr,   w_mem_wr;
    logic          r_mem_last, w_mem_last;
    logic          r_dec_done, w_dec_done;
    logic          r_seq_done, w_seq_done;

    logic [3:0]    w_mask;
    logic [7:0]    w_m8;
    logic [AW-1:0] w_next_dword;

    // Byte mask of the access, shifted into an 8-byte window starting at the dword base.
    always_comb begin
        case (r_size)
            2'd0:    w_mask = 4'b0001;
            2'd1:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        w_m8         = {4'b0000, w_mask} << acu_addr[1:0];
        w_next_dword = {acu_addr[AW-1:2] + (AW-2)'(1), 2'b00};
    end

    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_last_seq = r_last_seq;
        w_size     = r_size;
        w_wr       = r_wr;
        w_hi_be    = r_hi_be;
        w_a1       = r_a1;
        w_dec_gnt  = 1'b0;
        w_seq_gnt  = 1'b0;
        w_mem_req  = r_mem_req;
        w_mem_addr = r_mem_addr;
        w_mem_be   = r_mem_be;
        w_mem_seg  = r_mem_seg;
        w_mem_wr   = r_mem_wr;
        w_mem_last = r_mem_last;
        w_dec_done = 1'b0;
        w_seq_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (dec_req || seq_req) begin
                    // On a tie the requester not granted last wins.
                    w_sel   = (dec_req && seq_req) ? ~r_last_seq : seq_req;
                    w_size  = w_sel ? seq_size : dec_size;
                    w_wr    = w_sel ? seq_wr : dec_wr;
                    w_state = S_CALC;
                end
            end
            S_CALC: begin
                w_dec_gnt = ~r_sel;
                w_seq_gnt = r_sel;
                w_state   = S_CAP;
            end
            S_CAP: begin
                w_last_seq = r_sel;
                w_mem_req  = 1'b1;
                w_mem_addr = acu_addr;
                w_mem_be   = w_m8[3:0];
                w_hi_be    = w_m8[7:4];
                w_a1       = w_next_dword;
                w_mem_seg  = acu_seg;
                w_mem_wr   = r_wr;
                w_mem_last = ~|w_m8[7:4];
                w_state    = S_BEAT0;
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    if (r_mem_last) begin
                        w_mem_req  = 1'b0;
                        w_dec_done = ~r_sel;
                        w_seq_done = r_sel;
                        w_state    = S_IDLE;
                    end else begin
                        w_mem_addr = r_a1;
                        w_mem_be   = r_hi_be;
                        w_mem_last = 1'b1;
                        w_state    = S_BEAT1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    w_mem_req  = 1'b0;
                    w_dec_done = ~r_sel;
                    w_seq_done = r_sel;
                    w_state    = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_last_seq <= 1'b1;
            r_size     <= 2'd0;
            r_wr       <= 1'b0;
            r_hi_be    <= 4'd0;
            r_a1       <= '0;
            r_dec_gnt  <= 1'b0;
            r_seq_gnt  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_be   <= 4'd0;
            r_mem_seg  <= 3'd0;
            r_mem_wr   <= 1'b0;
            r_mem_last <= 1'b0;
            r_dec_done <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sel      <= w_sel;
            r_last_seq <= w_last_seq;
            r_size     <= w_size;
            r_wr       <= w_wr;
            r_hi_be    <= w_hi_be;
            r_a1       <= w_a1;
            r_dec_gnt  <= w_dec_gnt;
            r_seq_gnt  <= w_seq_gnt;
            r_mem_req  <= w_mem_req;
            r_mem_addr <= w_mem_addr;
            r_mem_be   <= w_mem_be;
            r_mem_seg  <= w_mem_seg;
            r_mem_wr   <= w_mem_wr;
            r_mem_last <= w_mem_last;
            r_dec_done <= w_dec_done;
            r_seq_done <= w_seq_done;
        end
    end

    assign acu_sel  = r_sel;
    assign dec_gnt  = r_dec_gnt;
    assign seq_gnt  = r_seq_gnt;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign mem_be   = r_mem_be;
    assign mem_seg  = r_mem_seg;
    assign mem_wr   = r_mem_wr;
    assign mem_src  = r_sel;
    assign mem_last = r_mem_last;
    assign dec_done = r_dec_done;
    assign seq_done = r_seq_done;

endmodule

// File: tb/tb_acu_arb.sv
// Bench for acu_arb: directed and randomized transactions checked against a
// transaction-level model of arbitration order and beat splitting.
module tb_acu_arb;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_req, seq_req, dec_wr, seq_wr;
    logic [1:0]    dec_size, seq_size;
    logic          dec_gnt, seq_gnt, acu_sel;
    logic [AW-1:0] acu_addr;
    logic [2:0]    acu_seg;
    logic          mem_req, mem_wr, mem_src, mem_last, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [2:0]    mem_seg;
    logic          dec_done, seq_done;

    int checks = 0;
    int errors = 0;
    bit last_seq = 1'b1;

    acu_arb #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .dec_req(dec_req), .dec_size(dec_size), .dec_wr(dec_wr), .dec_gnt(dec_gnt),
        .seq_req(seq_req), .seq_size(seq_size), .seq_wr(seq_wr), .seq_gnt(seq_gnt),
        .acu_sel(acu_sel), .acu_addr(acu_addr), .acu_seg(acu_seg),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_seg(mem_seg),
        .mem_wr(mem_wr), .mem_src(mem_src), .mem_last(mem_last), .mem_ack(mem_ack),
        .dec_done(dec_done), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                            input bit last, input logic [2:0] seg, input bit wr, input bit src);
        chk({tag, "_req"},  64'(mem_req), 64'(1));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, "_be"},   64'(mem_be), 64'(be));
        chk({tag, "_last"}, 64'(mem_last), 64'(last));
        chk({tag, "_seg"},  64'(mem_seg), 64'(seg));
        chk({tag, "_wr"},   64'(mem_wr), 64'(wr));
        chk({tag, "_src"},  64'(mem_src), 64'(src));
        chk({tag, "_quiet"}, 64'({dec_gnt, seq_gnt, dec_done, seq_done}), 64'(0));
    endtask

    // Starts in an IDLE cycle and ends in the IDLE cycle carrying the done pulse.
    task automatic do_txn(input bit dr, input bit sr, input logic [1:0] dsz, input logic [1:0] ssz,
                          input bit dwr, input bit swr, input logic [31:0] addr,
                          input logic [2:0] seg, input int w0, input int w1, input bit rst_b1);
        bit          win;
        logic [1:0]  sz;
        bit          wr;
        int          n;
        int          off;
        int unsigned m;
        bit          split;
        logic [3:0]  be0, be1;
        logic [31:0] a1;

        win   = (dr && sr) ? !last_seq : sr;
        sz    = win ? ssz : dsz;
        wr    = win ? swr : dwr;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        m     = ((32'd1 << n) - 32'd1) << off;
        split = (off + n) > 4;
        be0   = 4'(m);
        be1   = 4'(m >> 4);
        a1    = (addr & 32'hFFFF_FFFC) + 32'd4;

        dec_req = dr; seq_req = sr; dec_size = dsz; seq_size = ssz;
        dec_wr = dwr; seq_wr = swr; acu_addr = addr; acu_seg = seg;
        mem_ack = 1'($urandom);
        tick();
        chk("calc_sel", 64'(acu_sel), 64'(win));
        chk("calc_quiet", 64'({dec_gnt, seq_gnt, mem_req, dec_done, seq_done}), 64'(0));
        mem_ack = 1'($urandom);
        tick();
        chk("cap_sel", 64'(acu_sel), 64'(win));
        chk("cap_dgnt", 64'(dec_gnt), 64'(!win));
        chk("cap_sgnt", 64'(seq_gnt), 64'(win));
        chk("cap_mreq", 64'(mem_req), 64'(0));
        last_seq = win;
        mem_ack = 1'b0;
        tick();
        for (int w = 0; w <= w0; w++) begin
            chk_beat("b0", addr, be0, !split, seg, wr, win);
            mem_ack = (w == w0);
            tick();
        end
        mem_ack = 1'b0;
        if (split) begin
            if (rst_b1) begin
                chk_beat("b1r", a1, be1, 1'b1, seg, wr, win);
                rst = 1'b1;
                mem_ack = 1'b1;
                tick();
                rst = 1'b0;
                mem_ack = 1'b0;
                chk("rst_outs", 64'({dec_gnt, seq_gnt, acu_sel, mem_req, mem_addr, mem_be, mem_seg,
                                     mem_wr, mem_src, mem_last, dec_done, seq_done}), 64'(0));
                last_seq = 1'b1;
                return;
            end
            for (int w = 0; w <= w1; w++) begin
                chk_beat("b1", a1, be1, 1'b1, seg, wr, win);
                mem_ack = (w == w1);
                tick();
            end
            mem_ack = 1'b0;
        end
        chk("done_dec", 64'(dec_done), 64'(!win));
        chk("done_seq", 64'(seq_done), 64'(win));
        chk("done_mreq", 64'(mem_req), 64'(0));
    endtask

    initial begin
        rst = 1'b1; dec_req = 0; seq_req = 0; dec_size = 0; seq_size = 0;
        dec_wr = 0; seq_wr = 0; acu_addr = '0; acu_seg = '0; mem_ack = 0;
        tick();
        mem_ack = 1'b1;
        dec_req = 1'b1;
        tick();
        chk("reset_outs", 64'({dec_gnt, seq_gnt, acu_sel, mem_req, mem_addr, mem_be, mem_seg,
                               mem_wr, mem_src, mem_last, dec_done, seq_done}), 64'(0));
        rst = 1'b0; dec_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("idle_quiet", 64'({acu_sel, mem_req, dec_gnt, seq_gnt}), 64'(0));

        do_txn(1, 0, 2'd2, 2'd0, 1, 0, 32'h0000_1000, 3'd1, 0, 0, 0);
        do_txn(0, 1, 2'd0, 2'd1, 0, 1, 32'h0000_2003, 3'd2, 0, 0, 0);
        do_txn(0, 1, 2'd0, 2'd2, 0, 0, 32'hFFFF_FFFE, 3'd3, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            do_txn(1, 1, 2'd2, 2'd1, 1, 0, 32'h0000_5000 + 32'(i * 5), 3'(i), 0, 0, 0);
        do_txn(1, 0, 2'd1, 2'd0, 1, 0, 32'h0000_3001, 3'd5, 5, 0, 0);
        do_txn(1, 1, 2'd2, 2'd2, 0, 1, 32'h0000_4002, 3'd6, 0, 0, 1);
        do_txn(1, 1, 2'd0, 2'd3, 1, 1, 32'h0000_6007, 3'd7, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            bit          dr, sr;
            logic [31:0] a;
            dr = 1'($urandom);
            sr = 1'($urandom);
            if (!dr && !sr) dr = 1'b1;
            a = $urandom;
            if (i % 6 == 0) a = 32'hFFFF_FFFC | 32'(a[1:0]);
            do_txn(dr, sr, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), a,
                   3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        dec_req = 1'b0; seq_req = 1'b0;
        tick();
        chk("end_quiet", 64'({mem_req, dec_done, seq_done, dec_gnt, seq_gnt}), 64'(0));
        tick();
        chk("end_idle", 64'({mem_req, dec_gnt, seq_gnt}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
